// File: rtl/pc_next_ctrl_if.sv
// Program-counter write-side bus between pc_next_ctrl (master) and the PC/fetch side (slave).
// The misalign signal exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_next_ctrl_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] pc_out;
  logic              ihit;
  logic              stall;
  logic              branch_taken;
  logic [WORD_W-1:0] branch_target;
  logic              jump;
  logic [WORD_W-1:0] jump_target;
  logic              jr;
  logic [WORD_W-1:0] jr_target;
  logic              halt;
  logic [WORD_W-1:0] pc_in;
  logic              pcWEN;
  logic              imemREN;
  logic              halted;
`ifdef PC_ALIGN_CHECK_EN
  logic              misalign;
`endif

  modport master (
    input  pc_out, ihit, stall, branch_taken, branch_target,
    input  jump, jump_target, jr, jr_target, halt,
`ifdef PC_ALIGN_CHECK_EN
    output misalign,
`endif
    output pc_in, pcWEN, imemREN, halted
  );

  modport slave (
    output pc_out, ihit, stall, branch_taken, branch_target,
    output jump, jump_target, jr, jr_target, halt,
`ifdef PC_ALIGN_CHECK_EN
    input  misalign,
`endif
    input  pc_in, pcWEN, imemREN, halted
  );
endinterface

// File: rtl/pc_next_ctrl.sv
// Next-PC selection, stalled-redirect holding, imem read enable and sticky halt.
// Optional macro PC_ALIGN_CHECK_EN: forces word alignment of targets and adds a sticky misalign flag.
module pc_next_ctrl #(
  parameter int                WORD_W   = 32,
  parameter logic [WORD_W-1:0] PC_RESET = 32'h0000_0000,
  parameter int                PC_INC   = 4
) (
  input logic           CLK,
  input logic           RST,
  pc_next_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [WORD_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              halted_q, halted_d;

  logic              redir_s;
  logic              adv_s;
  logic [WORD_W-1:0] raw_tgt_s;
  logic [WORD_W-1:0] redir_tgt_s;
  logic [WORD_W-1:0] seq_pc_s;
  logic [WORD_W-1:0] pc_in_s;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
`endif

  // Redirect target, fixed priority jr > jump > branch
  always_comb begin
    redir_s = bus.jr | bus.jump | bus.branch_taken;
    if (bus.jr) begin
      raw_tgt_s = bus.jr_target;
    end else if (bus.jump) begin
      raw_tgt_s = bus.jump_target;
    end else begin
      raw_tgt_s = bus.branch_target;
    end
`ifdef PC_ALIGN_CHECK_EN
    redir_tgt_s = raw_tgt_s & {{(WORD_W-2){1'b1}}, 2'b00};
`else
    redir_tgt_s = raw_tgt_s;
`endif
    seq_pc_s = bus.pc_out + WORD_W'(PC_INC);
    adv_s    = (state_q == FETCH) & bus.ihit & ~bus.stall & ~bus.halt;
  end

  // Next state, pending redirect and pc_in selection
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    halted_d   = halted_q;
    pc_in_s    = PC_RESET;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        pc_in_s = seq_pc_s;
        if (bus.halt) begin
          state_d    = HALTED;
          pend_vld_d = 1'b0;
          halted_d   = 1'b1;
        end else if (adv_s) begin
          pend_vld_d = 1'b0;
          if (redir_s) begin
            pc_in_s = redir_tgt_s;
          end else if (pend_vld_q) begin
            pc_in_s = pend_tgt_q;
          end else begin
            pc_in_s = seq_pc_s;
          end
        end else if (redir_s) begin
          // Fetch is blocked: remember the newest redirect until the PC can move
          pend_vld_d = 1'b1;
          pend_tgt_d = redir_tgt_s;
        end else begin
          pend_vld_d = pend_vld_q;
        end
      end
      HALTED: begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end
      default: begin
        state_d    = BOOT;
        pend_vld_d = 1'b0;
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky flag for a selected redirect target that was not word aligned
  always_comb begin
    if ((state_q == FETCH) && redir_s && !bus.halt && (raw_tgt_s[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = misalign_q;
    end
  end
`endif

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= BOOT;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= {WORD_W{1'b0}};
      halted_q   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      halted_q   <= halted_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign bus.pc_in   = pc_in_s;
  assign bus.pcWEN   = adv_s;
  assign bus.imemREN = (state_q == FETCH);
  assign bus.halted  = halted_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl; the PC register is emulated by driving pc_out by hand.
// Also covers the PC_ALIGN_CHECK_EN build when that macro is defined.
module tb_pc_next_ctrl;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  pc_next_ctrl_if #(.WORD_W(32)) bus_if ();

  pc_next_ctrl #(
    .WORD_W  (32),
    .PC_RESET(32'h0000_0000),
    .PC_INC  (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.ihit          = 1'b0;
    bus_if.stall         = 1'b0;
    bus_if.branch_taken  = 1'b0;
    bus_if.branch_target = 32'h0;
    bus_if.jump          = 1'b0;
    bus_if.jump_target   = 32'h0;
    bus_if.jr            = 1'b0;
    bus_if.jr_target     = 32'h0;
    bus_if.halt          = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus_if.pc_out = 32'h0;
    idle_inputs();
    #2;
    chk("rst_pcwen",   {31'd0, bus_if.pcWEN},   32'd0);
    chk("rst_imemren", {31'd0, bus_if.imemREN}, 32'd0);
    chk("rst_pcin",    bus_if.pc_in,            32'h0);
    chk("rst_halted",  {31'd0, bus_if.halted},  32'd0);
    tick();
    RST = 1'b0;
    bus_if.ihit = 1'b1;
    #1;
    chk("boot_pcwen",   {31'd0, bus_if.pcWEN},   32'd0);
    chk("boot_imemren", {31'd0, bus_if.imemREN}, 32'd0);

    // sequential fetch
    tick();
    chk("seq0_pcwen", {31'd0, bus_if.pcWEN}, 32'd1);
    chk("seq0_pcin",  bus_if.pc_in, 32'h4);
    tick(); bus_if.pc_out = 32'h4; #1;
    chk("seq1_pcin",  bus_if.pc_in, 32'h8);
    tick(); bus_if.pc_out = 32'h8; #1;
    chk("seq2_pcin",  bus_if.pc_in, 32'hC);

    // priority
    tick();
    bus_if.pc_out = 32'h40;
    bus_if.branch_taken = 1'b1; bus_if.branch_target = 32'h100;
    bus_if.jump = 1'b1;         bus_if.jump_target   = 32'h200;
    #1;
    chk("prio_jump_pcin",  bus_if.pc_in, 32'h200);
    chk("prio_jump_pcwen", {31'd0, bus_if.pcWEN}, 32'd1);
    bus_if.jr = 1'b1; bus_if.jr_target = 32'h300;
    #1;
    chk("prio_jr_pcin", bus_if.pc_in, 32'h300);

    // pending redirect across fetch stall
    tick();
    idle_inputs();
    bus_if.pc_out = 32'h20;
    bus_if.jump = 1'b1; bus_if.jump_target = 32'h80;
    #1;
    chk("pend0_pcwen", {31'd0, bus_if.pcWEN}, 32'd0);
    tick(); bus_if.jump = 1'b0; #1;
    chk("pend1_pcwen", {31'd0, bus_if.pcWEN}, 32'd0);
    chk("pend1_pcin",  bus_if.pc_in, 32'h24);
    tick();
    chk("pend2_pcwen", {31'd0, bus_if.pcWEN}, 32'd0);
    tick(); bus_if.ihit = 1'b1; #1;
    chk("pend3_pcin",  bus_if.pc_in, 32'h80);
    chk("pend3_pcwen", {31'd0, bus_if.pcWEN}, 32'd1);
    tick(); bus_if.pc_out = 32'h80; #1;
    chk("pend4_pcin",  bus_if.pc_in, 32'h84);

    // newer pending redirect overwrites older one
    tick();
    bus_if.ihit = 1'b0;
    bus_if.branch_taken = 1'b1; bus_if.branch_target = 32'h100;
    tick();
    bus_if.branch_taken = 1'b0;
    bus_if.jump = 1'b1; bus_if.jump_target = 32'h200;
    tick();
    bus_if.jump = 1'b0; bus_if.ihit = 1'b1; #1;
    chk("overwrite_pcin", bus_if.pc_in, 32'h200);

    // data stall with ihit
    tick();
    idle_inputs();
    bus_if.pc_out = 32'h10; bus_if.ihit = 1'b1; bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pcwen",   {31'd0, bus_if.pcWEN},   32'd0);
      chk("stall_imemren", {31'd0, bus_if.imemREN}, 32'd1);
      tick();
    end
    bus_if.stall = 1'b0; #1;
    chk("unstall_pcin",  bus_if.pc_in, 32'h14);
    chk("unstall_pcwen", {31'd0, bus_if.pcWEN}, 32'd1);

    // wrap
    tick();
    bus_if.pc_out = 32'hFFFF_FFFC; #1;
    chk("wrap_pcin", bus_if.pc_in, 32'h0);

    // misaligned branch target
    tick();
    bus_if.pc_out = 32'h60;
    bus_if.branch_taken = 1'b1; bus_if.branch_target = 32'h103; #1;
`ifdef PC_ALIGN_CHECK_EN
    chk("align_pcin", bus_if.pc_in, 32'h100);
    tick();
    bus_if.branch_taken = 1'b0; bus_if.pc_out = 32'h100; #1;
    chk("misalign_set", {31'd0, bus_if.misalign}, 32'd1);
    tick();
    chk("misalign_sticky", {31'd0, bus_if.misalign}, 32'd1);
`else
    chk("passthru_pcin", bus_if.pc_in, 32'h103);
    tick();
    bus_if.branch_taken = 1'b0; bus_if.pc_out = 32'h100; #1;
`endif

    // halt
    tick();
    idle_inputs();
    bus_if.pc_out = 32'h50; bus_if.ihit = 1'b1; bus_if.halt = 1'b1; #1;
    chk("halt0_pcwen",  {31'd0, bus_if.pcWEN},  32'd0);
    chk("halt0_halted", {31'd0, bus_if.halted}, 32'd0);
    tick();
    bus_if.halt = 1'b0; #1;
    chk("halt1_halted",  {31'd0, bus_if.halted},  32'd1);
    chk("halt1_imemren", {31'd0, bus_if.imemREN}, 32'd0);
    bus_if.branch_taken = 1'b1; bus_if.branch_target = 32'h100; #1;
    chk("halt2_pcwen", {31'd0, bus_if.pcWEN}, 32'd0);
    chk("halt2_pcin",  bus_if.pc_in, 32'h0);
    tick();
    chk("halt3_pcwen",  {31'd0, bus_if.pcWEN},  32'd0);
    chk("halt3_halted", {31'd0, bus_if.halted}, 32'd1);
    RST = 1'b1; #1;
    chk("halt_rst_halted", {31'd0, bus_if.halted}, 32'd0);
    chk("halt_rst_pcwen",  {31'd0, bus_if.pcWEN},  32'd0);
    RST = 1'b0;
    idle_inputs();
    bus_if.pc_out = 32'h0; bus_if.ihit = 1'b1; #1;
    chk("reboot_imemren", {31'd0, bus_if.imemREN}, 32'd0);
    tick();
    chk("refetch_imemren", {31'd0, bus_if.imemREN}, 32'd1);
    chk("refetch_pcin",    bus_if.pc_in, 32'h4);

    // reset discards a pending redirect
    bus_if.ihit = 1'b0; bus_if.jump = 1'b1; bus_if.jump_target = 32'h80;
    tick();
    bus_if.jump = 1'b0;
    RST = 1'b1; #1; RST = 1'b0;
    tick();
    bus_if.ihit = 1'b1; #1;
    chk("rst_pend_pcin",  bus_if.pc_in, 32'h4);
    chk("rst_pend_pcwen", {31'd0, bus_if.pcWEN}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
